// File: rtl/maze_game_ctrl.sv
// Maze session controller: sequences carver generation, selects the maze size per level,
// owns the player position, validates moves against the carved bitmap and detects the goal.
module maze_game_ctrl #(
    parameter logic [25:0] GEN_SLOW_TIME = 26'd1000,
    parameter logic [25:0] MOVE_HOLDOFF  = 26'd5_000_000,
    parameter logic [3:0]  BUSY_WAIT     = 4'd15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_new,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         gen_finish,
    input  logic [255:0] maze_data,
    input  logic [3:0]   gen_finish_x,
    input  logic [3:0]   gen_finish_y,
    output logic         gen_start,
    output logic [25:0]  gen_slow_time,
    output logic [4:0]   maze_width,
    output logic [4:0]   maze_height,
    output logic [3:0]   player_x,
    output logic [3:0]   player_y,
    output logic [3:0]   goal_x,
    output logic [3:0]   goal_y,
    output logic [2:0]   level,
    output logic [2:0]   game_state,
    output logic         won
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StPlay     = 3'd4,
        StWon      = 3'd5
    } state_e;

    localparam int unsigned BtnNew   = 0;
    localparam int unsigned BtnUp    = 1;
    localparam int unsigned BtnLeft  = 2;
    localparam int unsigned BtnDown  = 3;
    localparam int unsigned BtnRight = 4;

    state_e      state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [4:0]  size_q, size_d;
    logic [3:0]  px_q, px_d;
    logic [3:0]  py_q, py_d;
    logic [3:0]  gx_q, gx_d;
    logic [3:0]  gy_q, gy_d;
    logic [25:0] hold_q, hold_d;
    logic [3:0]  busy_q, busy_d;
    logic [4:0]  btn_now;
    logic [4:0]  btn_prev_q;
    logic [4:0]  btn_edge_q;

    logic        mv_req;
    logic        mv_ok;
    logic        in_bounds;
    logic [4:0]  tx;
    logic [4:0]  ty;
    logic [7:0]  cell_idx;

    assign btn_now = {btn_right, btn_down, btn_left, btn_up, btn_new};

    // Only the highest-priority move edge is considered. Stepping up/left from 0 wraps to 31
    // in 5 bits, which the bounds compare then rejects.
    always_comb begin
        mv_req = 1'b1;
        tx     = {1'b0, px_q};
        ty     = {1'b0, py_q};
        if (btn_edge_q[BtnUp]) begin
            ty = {1'b0, py_q} - 5'd1;
        end else if (btn_edge_q[BtnLeft]) begin
            tx = {1'b0, px_q} - 5'd1;
        end else if (btn_edge_q[BtnDown]) begin
            ty = {1'b0, py_q} + 5'd1;
        end else if (btn_edge_q[BtnRight]) begin
            tx = {1'b0, px_q} + 5'd1;
        end else begin
            mv_req = 1'b0;
        end
    end

    assign in_bounds = (tx < size_q) && (ty < size_q);
    assign cell_idx  = {ty[3:0], tx[3:0]};
    assign mv_ok     = mv_req && in_bounds && (hold_q == '0) && maze_data[cell_idx];

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        px_d    = px_q;
        py_d    = py_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        busy_d  = busy_q;
        hold_d  = (hold_q != '0) ? hold_q - 26'd1 : hold_q;

        unique case (state_q)
            StIdle: begin
                if (btn_edge_q[BtnNew]) begin
                    level_d = 3'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                px_d    = 4'd0;
                py_d    = 4'd0;
                busy_d  = 4'd0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // A finish flag still high from the previous maze is not a completion.
                if (!gen_finish) begin
                    state_d = StWaitDone;
                end else if (busy_q == BUSY_WAIT) begin
                    state_d = StStart;
                end else begin
                    busy_d = busy_q + 4'd1;
                end
            end
            StWaitDone: begin
                if (gen_finish) begin
                    gx_d    = gen_finish_x;
                    gy_d    = gen_finish_y;
                    hold_d  = 26'd0;
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (btn_edge_q[BtnNew]) begin
                    state_d = StStart;
                end else if (px_q == gx_q && py_q == gy_q) begin
                    state_d = StWon;
                end else if (mv_ok) begin
                    px_d   = tx[3:0];
                    py_d   = ty[3:0];
                    hold_d = MOVE_HOLDOFF;
                end
            end
            StWon: begin
                if (btn_edge_q[BtnNew]) begin
                    level_d = (level_q == 3'd6) ? 3'd6 : level_q + 3'd1;
                    state_d = StStart;
                end
            end
            default: state_d = StIdle;
        endcase

        size_d = 5'd4 + {1'b0, level_d, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            level_q    <= 3'd0;
            size_q     <= 5'd4;
            px_q       <= 4'd0;
            py_q       <= 4'd0;
            gx_q       <= 4'd0;
            gy_q       <= 4'd0;
            hold_q     <= 26'd0;
            busy_q     <= 4'd0;
            btn_prev_q <= 5'd0;
            btn_edge_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            size_q     <= size_d;
            px_q       <= px_d;
            py_q       <= py_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            btn_prev_q <= btn_now;
            btn_edge_q <= btn_now & ~btn_prev_q;
        end
    end

    assign gen_start     = (state_q == StStart);
    assign won           = (state_q == StWon);
    assign game_state    = state_q;
    assign gen_slow_time = GEN_SLOW_TIME;
    assign maze_width    = size_q;
    assign maze_height   = size_q;
    assign player_x      = px_q;
    assign player_y      = py_q;
    assign goal_x        = gx_q;
    assign goal_y        = gy_q;
    assign level         = level_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Self-checking bench for maze_game_ctrl: directed scenarios plus randomized play, every
// cycle compared against a behavioural session model and a small carver model.
module tb_maze_game_ctrl;

    localparam int HOLD = 4;
    localparam int BW   = 15;
    localparam logic [4:0] NEW   = 5'b00001;
    localparam logic [4:0] UP    = 5'b00010;
    localparam logic [4:0] LEFT  = 5'b00100;
    localparam logic [4:0] DOWN  = 5'b01000;
    localparam logic [4:0] RIGHT = 5'b10000;

    logic         clk = 1'b0;
    logic         reset;
    logic         btn_new, btn_up, btn_down, btn_left, btn_right;
    logic         gen_finish;
    logic [255:0] maze_data;
    logic [3:0]   gen_finish_x, gen_finish_y;
    logic         gen_start;
    logic [25:0]  gen_slow_time;
    logic [4:0]   maze_width, maze_height;
    logic [3:0]   player_x, player_y, goal_x, goal_y;
    logic [2:0]   level;
    logic [2:0]   game_state;
    logic         won;

    maze_game_ctrl #(
        .GEN_SLOW_TIME(26'd1000),
        .MOVE_HOLDOFF (26'd4),
        .BUSY_WAIT    (4'd15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_new      (btn_new),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .gen_finish   (gen_finish),
        .maze_data    (maze_data),
        .gen_finish_x (gen_finish_x),
        .gen_finish_y (gen_finish_y),
        .gen_start    (gen_start),
        .gen_slow_time(gen_slow_time),
        .maze_width   (maze_width),
        .maze_height  (maze_height),
        .player_x     (player_x),
        .player_y     (player_y),
        .goal_x       (goal_x),
        .goal_y       (goal_y),
        .level        (level),
        .game_state   (game_state),
        .won          (won)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference session: state numbers are the ones visible on game_state.
    int         m_state = 0, m_level = 0, m_px = 0, m_py = 0, m_gx = 0, m_gy = 0;
    int         m_hold = 0, m_busy = 0;
    logic [4:0] m_prev = '0, m_edge = '0;
    int         prio[4] = '{1, 2, 3, 4};
    int         dx[4]   = '{0, -1, 0, 1};
    int         dy[4]   = '{-1, 0, 1, 0};

    // Carver model.
    int         car_mode = 0, car_lag_cfg = 2, car_busy_cfg = 20, car_lag = 0, car_busy = 0;
    bit         car_active = 0;
    logic [3:0] car_gx = 4'd3, car_gy = 4'd3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Advances the model by one clock using the inputs that the coming edge samples.
    task automatic model_step();
        logic [4:0] now;
        int hold_now, tx, ty, sz;
        bit seen;
        now = {btn_right, btn_down, btn_left, btn_up, btn_new};
        if (reset) begin
            m_state = 0; m_level = 0; m_px = 0; m_py = 0; m_gx = 0; m_gy = 0;
            m_hold = 0; m_busy = 0; m_prev = '0; m_edge = '0;
            return;
        end
        hold_now = m_hold;
        if (m_hold > 0) m_hold--;
        sz = 4 + 2 * m_level;
        case (m_state)
            0: if (m_edge[0]) begin m_level = 0; m_state = 1; end
            1: begin m_px = 0; m_py = 0; m_busy = 0; m_state = 2; end
            2: begin
                if (!gen_finish) m_state = 3;
                else if (m_busy == BW) m_state = 1;
                else m_busy++;
            end
            3: if (gen_finish) begin
                m_gx = gen_finish_x; m_gy = gen_finish_y; m_hold = 0; m_state = 4;
            end
            4: begin
                if (m_edge[0]) m_state = 1;
                else if (m_px == m_gx && m_py == m_gy) m_state = 5;
                else begin
                    seen = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (!seen && m_edge[prio[k]]) begin
                            seen = 1;
                            tx = m_px + dx[k];
                            ty = m_py + dy[k];
                            if (hold_now == 0 && tx >= 0 && tx < sz && ty >= 0 && ty < sz) begin
                                if (maze_data[tx + 16 * ty]) begin
                                    m_px = tx; m_py = ty; m_hold = HOLD;
                                end
                            end
                        end
                    end
                end
            end
            5: if (m_edge[0]) begin
                m_level = (m_level < 6) ? m_level + 1 : 6; m_state = 1;
            end
            default: m_state = 0;
        endcase
        m_edge = now & ~m_prev;
        m_prev = now;
    endtask

    task automatic carver_step();
        if (gen_start === 1'b1) begin
            car_active = (car_mode == 0);
            car_lag    = car_lag_cfg;
            car_busy   = car_busy_cfg;
        end else if (car_active) begin
            if (car_lag > 0) car_lag--;
            else if (car_busy > 0) begin gen_finish = 1'b0; car_busy--; end
            else begin
                gen_finish = 1'b1; gen_finish_x = car_gx; gen_finish_y = car_gy;
                car_active = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_eq("state", game_state, m_state);
        check_eq("gen_start", gen_start, m_state == 1);
        check_eq("won", won, m_state == 5);
        check_eq("level", level, m_level);
        check_eq("width", maze_width, 4 + 2 * m_level);
        check_eq("height", maze_height, 4 + 2 * m_level);
        check_eq("player_x", player_x, m_px);
        check_eq("player_y", player_y, m_py);
        check_eq("goal_x", goal_x, m_gx);
        check_eq("goal_y", goal_y, m_gy);
        check_eq("slow_time", gen_slow_time, 1000);
        carver_step();
    endtask

    task automatic press(input logic [4:0] mask);
        {btn_right, btn_down, btn_left, btn_up, btn_new} = mask;
        tick();
        {btn_right, btn_down, btn_left, btn_up, btn_new} = 5'b0;
        tick();
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n = 0;
        while (game_state !== 3'(st) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, game_state, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, sz, lvl_exp, steps;
        logic [3:0] cur_gx, cur_gy;
        reset = 1'b1;
        {btn_right, btn_down, btn_left, btn_up, btn_new} = 5'b0;
        gen_finish = 1'b1; gen_finish_x = 4'd0; gen_finish_y = 4'd0;
        maze_data = '0;
        repeat (3) tick();
        check_eq("rst_state", game_state, 0);
        check_eq("rst_width", maze_width, 4);
        reset = 1'b0;
        tick();

        // First generation: state sequence 1 -> 2 -> 3 -> 4, goal (3,3).
        btn_new = 1'b1;
        tick();
        check_eq("idle_edge_reg", game_state, 0);
        btn_new = 1'b0;
        tick();
        check_eq("start_state", game_state, 1);
        check_eq("start_pulse", gen_start, 1);
        tick();
        check_eq("wait_busy", game_state, 2);
        check_eq("start_once", gen_start, 0);
        wait_state(3, 20, "wait_done");
        wait_state(4, 40, "play");
        check_eq("goal_x33", goal_x, 3);
        check_eq("goal_y33", goal_y, 3);
        check_eq("player0", {player_x, player_y}, 0);

        // Carver never drops finish: one START every BW+2 cycles.
        maze_data = '0;
        maze_data[0] = 1'b1; maze_data[1] = 1'b1; maze_data[17] = 1'b1;
        car_mode = 1; car_lag_cfg = 1; car_busy_cfg = 3;
        press(NEW);
        check_eq("retry_start", game_state, 1);
        pulses = 1;
        for (int i = 0; i < 3 * (BW + 2); i++) begin
            tick();
            if (gen_start === 1'b1) pulses++;
        end
        check_eq("retry_pulses", pulses, 4);
        car_mode = 0;
        wait_state(4, 80, "play_after_retry");

        // Moves, holdoff and boundary rejection.
        press(RIGHT);
        check_eq("mv_right_x", player_x, 1);
        check_eq("mv_right_y", player_y, 0);
        tick();
        press(DOWN);
        check_eq("holdoff_y", player_y, 0);
        repeat (4) tick();
        press(LEFT);
        check_eq("mv_left_x", player_x, 0);
        repeat (4) tick();
        press(UP);
        check_eq("up_at_top", {player_x, player_y}, 0);
        repeat (4) tick();
        press(DOWN);
        check_eq("blocked_down", {player_x, player_y}, 0);

        // Priority and btn_new precedence.
        maze_data = '1;
        repeat (4) tick();
        press(DOWN);
        check_eq("open_down", player_y, 1);
        repeat (4) tick();
        press(UP | RIGHT);
        check_eq("prio_up_x", player_x, 0);
        check_eq("prio_up_y", player_y, 0);
        repeat (4) tick();
        press(RIGHT);
        check_eq("right_again", player_x, 1);
        repeat (4) tick();
        press(NEW | RIGHT);
        check_eq("new_wins", game_state, 1);
        tick();
        check_eq("new_clears_x", player_x, 0);
        wait_state(4, 40, "play_regen");

        // Walk to the goal at every level, including the saturation at level 6.
        cur_gx = 4'd3; cur_gy = 4'd3;
        for (int it = 0; it < 8; it++) begin
            steps = 0;
            while ((player_x != cur_gx || player_y != cur_gy) && steps < 40) begin
                if (player_x < cur_gx) press(RIGHT);
                else if (player_x > cur_gx) press(LEFT);
                else if (player_y < cur_gy) press(DOWN);
                else press(UP);
                steps++;
                if (player_x != cur_gx || player_y != cur_gy) repeat (4) tick();
            end
            check_eq("at_goal_play", game_state, 4);
            tick();
            check_eq("win_latency", game_state, 5);
            check_eq("won_flag", won, 1);
            repeat (4) tick();
            press(LEFT);
            press(UP);
            check_eq("won_freeze", {player_x, player_y}, {cur_gx, cur_gy});
            lvl_exp = (it + 1 < 6) ? it + 1 : 6;
            sz = 4 + 2 * lvl_exp;
            cur_gx = 4'($urandom_range(1, sz - 1));
            cur_gy = 4'($urandom_range(0, sz - 1));
            car_gx = cur_gx; car_gy = cur_gy;
            press(NEW);
            wait_state(4, 60, "play_level");
            check_eq("level_up", level, lvl_exp);
            check_eq("size_up", maze_width, sz);
        end

        // Randomized play with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) begin
                if ($urandom_range(0, 1) == 0) maze_data = '1;
                else for (int w = 0; w < 8; w++) maze_data[w * 32 +: 32] = $urandom();
            end
            btn_new   = ($urandom_range(0, 40) == 0);
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_down  = ($urandom_range(0, 3) == 0);
            btn_left  = ($urandom_range(0, 3) == 0);
            btn_right = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 300) == 0);
            car_lag_cfg  = $urandom_range(0, 3);
            car_busy_cfg = $urandom_range(1, 6);
            car_gx = 4'($urandom_range(0, 3 + 2 * m_level));
            car_gy = 4'($urandom_range(0, 3 + 2 * m_level));
            tick();
        end
        {btn_right, btn_down, btn_left, btn_up, btn_new} = 5'b0;

        // Reset during WAIT_DONE.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        car_lag_cfg = 1; car_busy_cfg = 25;
        press(NEW);
        wait_state(3, 20, "wd_reach");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("wd_rst_state", game_state, 0);
        check_eq("wd_rst_gs", gen_start, 0);
        check_eq("wd_rst_goal", {goal_x, goal_y}, 0);
        check_eq("wd_rst_size", maze_height, 4);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gen_start === 1'b1) pulses++;
        end
        check_eq("wd_no_start", pulses, 0);
        press(NEW);
        check_eq("wd_restart", gen_start, 1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
